// File: rtl/adder_pipe_if.sv
// rtl/adder_pipe_if.sv - operand/result stream bundle for the pipelined adder
interface adder_pipe_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
);
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic             c_in;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] sum;
    logic             c_out;
    logic             out_valid;
    logic             out_ready;
    logic [CNT_W-1:0] ovf_count;

    modport master (
        output a_in, b_in, c_in, in_valid, out_ready,
        input  in_ready, sum, c_out, out_valid, ovf_count
    );

    modport slave (
        input  a_in, b_in, c_in, in_valid, out_ready,
        output in_ready, sum, c_out, out_valid, ovf_count
    );
endinterface

// File: rtl/adder_pipe.sv
// rtl/adder_pipe.sv - pipelined unsigned chunked adder with carry-event counter; ADDER_SAT_EN selects saturating sum
module adder_pipe #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2,
    parameter int CNT_W  = 8
) (
    input  logic       wb_clk_i,
    input  logic       wb_rst_i,
    adder_pipe_if.slave bus
);
    localparam int CHUNK = WIDTH / STAGES;

`ifdef ADDER_SAT_EN
    localparam bit SAT_EN = 1'b1;
`else
    localparam bit SAT_EN = 1'b0;
`endif

    if (WIDTH % STAGES != 0) begin : g_bad_cfg
        $error("adder_pipe: WIDTH must be a multiple of STAGES");
    end

    // Whole pipe moves as one; it only stalls when a result is waiting unconsumed.
    logic adv;
    assign adv          = !bus.out_valid || bus.out_ready;
    assign bus.in_ready = adv;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        // Operand bits still to be added (this chunk and above) and sum bits completed so far.
        localparam int SRC_W = WIDTH - k * CHUNK;
        localparam int SUM_W = (k + 1) * CHUNK;

        logic [SRC_W-1:0] a_src;
        logic [SRC_W-1:0] b_src;
        logic             c_src;
        logic             v_src;
        logic [CHUNK:0]   part;
        logic [SUM_W-1:0] s_raw;
        logic [SUM_W-1:0] s_nxt;
        logic             v_q;
        logic             cy_q;
        logic [SUM_W-1:0] s_q;

        if (k == 0) begin : g_head
            assign a_src = bus.a_in;
            assign b_src = bus.b_in;
            assign c_src = bus.c_in;
            assign v_src = bus.in_valid;
            assign s_raw = part[CHUNK-1:0];
        end else begin : g_body
            assign a_src = g_stage[k-1].g_hold.a_q;
            assign b_src = g_stage[k-1].g_hold.b_q;
            assign c_src = g_stage[k-1].cy_q;
            assign v_src = g_stage[k-1].v_q;
            assign s_raw = {part[CHUNK-1:0], g_stage[k-1].s_q};
        end

        assign part = {1'b0, a_src[CHUNK-1:0]} + {1'b0, b_src[CHUNK-1:0]} + {{CHUNK{1'b0}}, c_src};

        // Saturation only touches the last stage, so the carry chain and latency are unaffected.
        assign s_nxt = (SAT_EN && (k == STAGES - 1) && part[CHUNK]) ? {SUM_W{1'b1}} : s_raw;

        // Stage result register: valid bit, chunk carry and accumulated low sum bits.
        always_ff @(posedge wb_clk_i) begin
            if (wb_rst_i) begin
                v_q  <= 1'b0;
                cy_q <= 1'b0;
                s_q  <= '0;
            end else if (adv) begin
                v_q  <= v_src;
                cy_q <= part[CHUNK];
                s_q  <= s_nxt;
            end
        end

        if (k < STAGES - 1) begin : g_hold
            logic [SRC_W-CHUNK-1:0] a_q;
            logic [SRC_W-CHUNK-1:0] b_q;

            // Delay the not-yet-added upper operand chunks alongside the partial sum.
            always_ff @(posedge wb_clk_i) begin
                if (wb_rst_i) begin
                    a_q <= '0;
                    b_q <= '0;
                end else if (adv) begin
                    a_q <= a_src[SRC_W-1:CHUNK];
                    b_q <= b_src[SRC_W-1:CHUNK];
                end
            end
        end
    end

    assign bus.sum       = g_stage[STAGES-1].s_q;
    assign bus.c_out     = g_stage[STAGES-1].cy_q;
    assign bus.out_valid = g_stage[STAGES-1].v_q;

    logic [CNT_W-1:0] cnt_q;
    assign bus.ovf_count = cnt_q;

    // Count carry-out results as they are handed off; sticks at all-ones.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            cnt_q <= '0;
        end else if (bus.out_valid && bus.out_ready && bus.c_out && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_adder_pipe.sv
// tb/tb_adder_pipe.sv - directed and scoreboard bench for adder_pipe (8b/2 stages and 32b/4 stages)
module tb_adder_pipe;
`ifdef ADDER_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic clk;
    logic rst;
    int   tests;
    int   fails;

    adder_pipe_if #(.WIDTH(8),  .CNT_W(2)) bus8 ();
    adder_pipe_if #(.WIDTH(32), .CNT_W(8)) bus32 ();

    adder_pipe #(.WIDTH(8), .STAGES(2), .CNT_W(2)) u_dut8 (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .bus      (bus8)
    );

    adder_pipe #(.WIDTH(32), .STAGES(4), .CNT_W(8)) u_dut32 (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .bus      (bus32)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] s8(input logic [8:0] full);
        return (SAT && full[8]) ? 8'hFF : full[7:0];
    endfunction

    function automatic logic [31:0] s32(input logic [32:0] full);
        return (SAT && full[32]) ? 32'hFFFF_FFFF : full[31:0];
    endfunction

    logic [32:0] q[$];
    logic [32:0] exp32;
    int          sent;
    int          got;
    int          gaps;
    int          stale;
    logic        acc;

    initial begin
        tests = 0;
        fails = 0;
        rst   = 1'b1;
        bus8.a_in = '0;  bus8.b_in = '0;  bus8.c_in = 1'b0;  bus8.in_valid = 1'b0;  bus8.out_ready = 1'b1;
        bus32.a_in = '0; bus32.b_in = '0; bus32.c_in = 1'b0; bus32.in_valid = 1'b0; bus32.out_ready = 1'b1;
        @(negedge clk);
        tick();
        tick();
        rst = 1'b0;

        // reset state
        check("rst_out_valid", 64'(bus8.out_valid), 64'd0);
        check("rst_sum",       64'(bus8.sum),       64'd0);
        check("rst_c_out",     64'(bus8.c_out),     64'd0);
        check("rst_ovf",       64'(bus8.ovf_count), 64'd0);
        check("rst_in_ready",  64'(bus8.in_ready),  64'd1);

        // 1: 0x7F + 0x01, latency 2, one-cycle valid
        bus8.a_in = 8'h7F; bus8.b_in = 8'h01; bus8.c_in = 1'b0; bus8.in_valid = 1'b1;
        tick();
        bus8.in_valid = 1'b0;
        check("t1_not_early", 64'(bus8.out_valid), 64'd0);
        tick();
        check("t1_valid", 64'(bus8.out_valid), 64'd1);
        check("t1_sum",   64'(bus8.sum),       64'h80);
        check("t1_c_out", 64'(bus8.c_out),     64'd0);
        tick();
        check("t1_one_cycle", 64'(bus8.out_valid), 64'd0);

        // 2: 0xFF + 0x01 carries out
        bus8.a_in = 8'hFF; bus8.b_in = 8'h01; bus8.c_in = 1'b0; bus8.in_valid = 1'b1;
        tick();
        bus8.in_valid = 1'b0;
        tick();
        check("t2_valid", 64'(bus8.out_valid), 64'd1);
        check("t2_c_out", 64'(bus8.c_out),     64'd1);
        check("t2_sum",   64'(bus8.sum),       64'(s8(9'h100)));
        check("t2_ovf_before", 64'(bus8.ovf_count), 64'd0);
        tick();
        check("t2_ovf_after",  64'(bus8.ovf_count), 64'd1);

        // 3: 0x0F + 0x00 + 1 crosses the chunk boundary
        bus8.a_in = 8'h0F; bus8.b_in = 8'h00; bus8.c_in = 1'b1; bus8.in_valid = 1'b1;
        tick();
        bus8.in_valid = 1'b0;
        tick();
        check("t3_valid", 64'(bus8.out_valid), 64'd1);
        check("t3_sum",   64'(bus8.sum),       64'h10);
        check("t3_c_out", 64'(bus8.c_out),     64'd0);
        tick();

        // 4: backpressure with three results queued
        bus8.out_ready = 1'b0;
        bus8.a_in = 8'h10; bus8.b_in = 8'h20; bus8.c_in = 1'b0; bus8.in_valid = 1'b1;
        tick();
        check("t4_in_ready_fill", 64'(bus8.in_ready), 64'd1);
        bus8.a_in = 8'hF0; bus8.b_in = 8'h20; bus8.c_in = 1'b0;
        tick();
        bus8.a_in = 8'h01; bus8.b_in = 8'h02; bus8.c_in = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check("t4_hold_valid",    64'(bus8.out_valid), 64'd1);
            check("t4_hold_sum",      64'(bus8.sum),       64'h30);
            check("t4_hold_c_out",    64'(bus8.c_out),     64'd0);
            check("t4_hold_in_ready", 64'(bus8.in_ready),  64'd0);
            tick();
        end
        bus8.out_ready = 1'b1;
        tick();
        bus8.in_valid = 1'b0;
        check("t4_r2_valid", 64'(bus8.out_valid), 64'd1);
        check("t4_r2_sum",   64'(bus8.sum),       64'(s8(9'h110)));
        check("t4_r2_c_out", 64'(bus8.c_out),     64'd1);
        tick();
        check("t4_r3_valid", 64'(bus8.out_valid), 64'd1);
        check("t4_r3_sum",   64'(bus8.sum),       64'h04);
        check("t4_r3_c_out", 64'(bus8.c_out),     64'd0);
        check("t4_ovf",      64'(bus8.ovf_count), 64'd2);
        tick();
        check("t4_drained",  64'(bus8.out_valid), 64'd0);
        check("t4_ovf_end",  64'(bus8.ovf_count), 64'd2);

        // 5: saturating counter, then reset mid-stream
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t5_ovf_cleared", 64'(bus8.ovf_count), 64'd0);
        bus8.a_in = 8'hFF; bus8.b_in = 8'h01; bus8.c_in = 1'b0; bus8.in_valid = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        bus8.in_valid = 1'b0;
        tick();
        tick();
        check("t5_drained", 64'(bus8.out_valid), 64'd0);
        check("t5_ovf_sat", 64'(bus8.ovf_count), 64'd3);
        bus8.a_in = 8'h80; bus8.b_in = 8'h80; bus8.c_in = 1'b0; bus8.in_valid = 1'b1;
        tick();
        tick();
        bus8.in_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t5_rst_valid", 64'(bus8.out_valid), 64'd0);
        check("t5_rst_ovf",   64'(bus8.ovf_count), 64'd0);
        check("t5_rst_sum",   64'(bus8.sum),       64'd0);
        stale = 0;
        for (int i = 0; i < 3; i++) begin
            if (bus8.out_valid) stale++;
            tick();
        end
        check("t5_no_stale", 64'(stale), 64'd0);

        // 6: 32-bit / 4-stage random stream against a scoreboard
        sent = 0;
        got  = 0;
        gaps = 0;
        acc  = 1'b0;
        for (int cyc = 0; cyc < 3000 && (sent < 200 || q.size() > 0); cyc++) begin
            bus32.out_ready = (cyc < 40) ? 1'b1 : ($urandom_range(0, 3) != 0);
            if (sent < 200) begin
                if (acc || !bus32.in_valid) begin
                    bus32.a_in     = $urandom;
                    bus32.b_in     = $urandom;
                    bus32.c_in     = 1'($urandom_range(0, 1));
                    bus32.in_valid = 1'b1;
                end
            end else begin
                bus32.in_valid = 1'b0;
            end
            #1;
            if (cyc >= 4 && cyc < 40 && !bus32.out_valid) gaps++;
            if (bus32.out_valid && bus32.out_ready) begin
                if (q.size() == 0) begin
                    check("t6_unexpected_result", 64'(bus32.out_valid), 64'd0);
                end else begin
                    exp32 = q.pop_front();
                    check("t6_sum",   64'(bus32.sum),   64'(s32(exp32)));
                    check("t6_c_out", 64'(bus32.c_out), 64'(exp32[32]));
                    got++;
                end
            end
            acc = bus32.in_valid && bus32.in_ready;
            if (acc) begin
                q.push_back({1'b0, bus32.a_in} + {1'b0, bus32.b_in} + {32'd0, bus32.c_in});
                sent++;
            end
            tick();
        end
        check("t6_results", 64'(got), 64'd200);
        check("t6_queue_empty", 64'(q.size()), 64'd0);
        check("t6_full_rate", 64'(gaps), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
